// File: rtl/i2c_tx_fifo.sv
//------------------------------------------------------------------------------
// Module   : i2c_tx_fifo
// Function : First-word-fall-through byte FIFO feeding the I2C slave transmitter.
//            Optional sticky error flags enabled by macro I2C_TX_FIFO_ERR_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module i2c_tx_fifo #(
   parameter int DEPTH     = 16,
   parameter int AF_THRESH = 12
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         wr_en,
   input  logic [7:0]                   wr_data,
   output logic                         full,
   output logic                         almost_full,
   output logic [$clog2(DEPTH+1)-1:0]   level,
   input  logic                         flush,
   output logic                         fifo_valid,
   output logic [7:0]                   fifo_dout,
   input  logic                         fifo_rd_en,
   output logic                         overflow,
   output logic                         underflow,
   input  logic                         err_clr
);

   localparam int c_ptr_w = $clog2(DEPTH);
   localparam int c_lvl_w = $clog2(DEPTH+1);
   localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);
   localparam logic [c_lvl_w-1:0] c_depth   = c_lvl_w'(DEPTH);
   localparam logic [c_lvl_w-1:0] c_af      = c_lvl_w'(AF_THRESH);

   logic [7:0]          r_mem [DEPTH];
   logic [c_ptr_w-1:0]  r_wptr;
   logic [c_ptr_w-1:0]  r_rptr;
   logic [c_lvl_w-1:0]  r_ram_cnt;
   logic [c_lvl_w-1:0]  r_level;
   logic                r_valid;
   logic [7:0]          r_dout;
   logic                r_full;
   logic                r_af;

   logic                w_wr_acc;
   logic                w_pop;
   logic                w_load;
   logic                w_valid_nxt;
   logic [c_lvl_w-1:0]  w_ram_cnt_nxt;
   logic [c_lvl_w-1:0]  w_level_nxt;

   always_comb begin
      w_wr_acc      = wr_en & ~r_full;
      w_pop         = fifo_rd_en & r_valid;
      // Prefetch only from bytes already in RAM before this edge.
      w_load        = (~r_valid | w_pop) & (r_ram_cnt != '0);
      w_ram_cnt_nxt = r_ram_cnt + c_lvl_w'(w_wr_acc) - c_lvl_w'(w_load);
      w_valid_nxt   = w_load | (r_valid & ~w_pop);
      w_level_nxt   = w_ram_cnt_nxt + c_lvl_w'(w_valid_nxt);
   end

   always_ff @(posedge clk) begin
      if (w_wr_acc && !flush) begin
         r_mem[r_wptr] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr    <= '0;
         r_rptr    <= '0;
         r_ram_cnt <= '0;
         r_level   <= '0;
         r_valid   <= 1'b0;
         r_dout    <= 8'h00;
         r_full    <= 1'b0;
         r_af      <= 1'b0;
      end else if (flush) begin
         // Head byte value is left in place; only its valid flag is cleared.
         r_wptr    <= '0;
         r_rptr    <= '0;
         r_ram_cnt <= '0;
         r_level   <= '0;
         r_valid   <= 1'b0;
         r_full    <= 1'b0;
         r_af      <= 1'b0;
      end else begin
         if (w_wr_acc) begin
            r_wptr <= r_wptr + c_ptr_one;
         end
         if (w_load) begin
            r_rptr <= r_rptr + c_ptr_one;
            r_dout <= r_mem[r_rptr];
         end
         r_ram_cnt <= w_ram_cnt_nxt;
         r_valid   <= w_valid_nxt;
         r_level   <= w_level_nxt;
         r_full    <= (w_level_nxt == c_depth);
         r_af      <= (w_level_nxt >= c_af);
      end
   end

`ifdef I2C_TX_FIFO_ERR_EN
   logic r_overflow;
   logic r_underflow;

   // A new error event outranks a simultaneous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (wr_en && r_full) begin
            r_overflow <= 1'b1;
         end else if (err_clr) begin
            r_overflow <= 1'b0;
         end
         if (fifo_rd_en && !r_valid) begin
            r_underflow <= 1'b1;
         end else if (err_clr) begin
            r_underflow <= 1'b0;
         end
      end
   end

   assign overflow  = r_overflow;
   assign underflow = r_underflow;
`else
   logic w_unused_err_clr;

   assign w_unused_err_clr = err_clr;
   assign overflow         = 1'b0;
   assign underflow        = 1'b0;
`endif

   assign full        = r_full;
   assign almost_full = r_af;
   assign level       = r_level;
   assign fifo_valid  = r_valid;
   assign fifo_dout   = r_dout;

endmodule

`default_nettype wire

// File: tb/tb_i2c_tx_fifo.sv
//------------------------------------------------------------------------------
// Module   : tb_i2c_tx_fifo
// Function : Self-checking bench for i2c_tx_fifo using a queue-based model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_i2c_tx_fifo;

   localparam int DEPTH     = 16;
   localparam int AF_THRESH = 12;
   localparam int c_lvl_w   = $clog2(DEPTH+1);
`ifdef I2C_TX_FIFO_ERR_EN
   localparam bit c_err = 1'b1;
`else
   localparam bit c_err = 1'b0;
`endif

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               wr_en = 1'b0;
   logic [7:0]         wr_data = 8'h00;
   logic               flush = 1'b0;
   logic               fifo_rd_en = 1'b0;
   logic               err_clr = 1'b0;
   logic               full;
   logic               almost_full;
   logic [c_lvl_w-1:0] level;
   logic               fifo_valid;
   logic [7:0]         fifo_dout;
   logic               overflow;
   logic               underflow;

   int n_tests = 0;
   int n_fail  = 0;
   bit check_en = 1'b0;

   i2c_tx_fifo #(.DEPTH(DEPTH), .AF_THRESH(AF_THRESH)) dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
      .full(full), .almost_full(almost_full), .level(level), .flush(flush),
      .fifo_valid(fifo_valid), .fifo_dout(fifo_dout), .fifo_rd_en(fifo_rd_en),
      .overflow(overflow), .underflow(underflow), .err_clr(err_clr)
   );

   always #5 clk = ~clk;

   // Model: RAM contents as a queue plus the output register.
   logic [7:0] q_ram [$];
   bit         m_valid;
   logic [7:0] m_dout;
   bit         m_ovf;
   bit         m_unf;

   function automatic int m_level();
      return q_ram.size() + (m_valid ? 1 : 0);
   endfunction

   task automatic m_reset();
      q_ram.delete();
      m_valid = 1'b0;
      m_dout  = 8'h00;
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
   endtask

   always @(posedge clk) begin
      if (rst_n) begin
         automatic bit was_full = (m_level() == DEPTH);
         automatic bit pop      = fifo_rd_en && m_valid;
         if (c_err) begin
            if (wr_en && was_full) m_ovf = 1'b1;
            else if (err_clr)      m_ovf = 1'b0;
            if (fifo_rd_en && !m_valid) m_unf = 1'b1;
            else if (err_clr)           m_unf = 1'b0;
         end
         if (flush) begin
            q_ram.delete();
            m_valid = 1'b0;
         end else begin
            if ((!m_valid || pop) && q_ram.size() > 0) begin
               m_dout  = q_ram.pop_front();
               m_valid = 1'b1;
            end else if (pop) begin
               m_valid = 1'b0;
            end
            if (wr_en && !was_full) q_ram.push_back(wr_data);
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (check_en) begin
         chk("cmp_valid", int'(fifo_valid), int'(m_valid));
         chk("cmp_dout", int'(fifo_dout), int'(m_dout));
         chk("cmp_level", int'(level), m_level());
         chk("cmp_full", int'(full), int'(m_level() == DEPTH));
         chk("cmp_afull", int'(almost_full), int'(m_level() >= AF_THRESH));
         chk("cmp_ovf", int'(overflow), int'(m_ovf));
         chk("cmp_unf", int'(underflow), int'(m_unf));
      end
   end

   // Applies one cycle of inputs; returns at the following falling edge.
   task automatic cyc(input bit w, input logic [7:0] d, input bit r,
                      input bit f, input bit ec);
      wr_en = w; wr_data = d; fifo_rd_en = r; flush = f; err_clr = ec;
      @(posedge clk);
      @(negedge clk);
      wr_en = 1'b0; fifo_rd_en = 1'b0; flush = 1'b0; err_clr = 1'b0;
   endtask

   initial begin
      m_reset();
      @(negedge clk);
      @(negedge clk);
      check_en = 1'b1;
      chk("rst_valid", int'(fifo_valid), 0);
      chk("rst_dout", int'(fifo_dout), 0);
      chk("rst_level", int'(level), 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Single byte latency.
      cyc(1, 8'hA5, 0, 0, 0);
      chk("lat_valid_e0", int'(fifo_valid), 0);
      chk("lat_level_e0", int'(level), 1);
      cyc(0, 8'h00, 0, 0, 0);
      chk("lat_valid_e1", int'(fifo_valid), 1);
      chk("lat_dout_e1", int'(fifo_dout), 8'hA5);
      cyc(0, 8'h00, 1, 0, 0);
      chk("pop_valid", int'(fifo_valid), 0);
      chk("pop_level", int'(level), 0);

      // Fill to full, overflow, drain in order.
      for (int i = 0; i < 16; i++) begin
         cyc(1, 8'(i), 0, 0, 0);
         if (i == 10) chk("af_at11", int'(almost_full), 0);
         if (i == 11) chk("af_at12", int'(almost_full), 1);
      end
      chk("fill_full", int'(full), 1);
      chk("fill_level", int'(level), 16);
      cyc(1, 8'hFF, 0, 0, 0);
      chk("ovf_flag", int'(overflow), int'(c_err));
      chk("ovf_level", int'(level), 16);
      for (int i = 0; i < 16; i++) begin
         chk("drain_dout", int'(fifo_dout), i);
         chk("drain_valid", int'(fifo_valid), 1);
         cyc(0, 8'h00, 1, 0, 0);
      end
      chk("drain_empty", int'(fifo_valid), 0);
      cyc(0, 8'h00, 0, 0, 1);
      chk("ovf_clr", int'(overflow), 0);

      // Wrap-around: two rounds of ten.
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < 10; i++) cyc(1, 8'(8'h10 + r*10 + i), 0, 0, 0);
         cyc(0, 8'h00, 0, 0, 0);
         for (int i = 0; i < 10; i++) begin
            chk("wrap_dout", int'(fifo_dout), 8'h10 + r*10 + i);
            cyc(0, 8'h00, 1, 0, 0);
         end
         chk("wrap_level", int'(level), 0);
      end

      // Head stability while writes continue.
      cyc(1, 8'h55, 0, 0, 0);
      cyc(0, 8'h00, 0, 0, 0);
      for (int i = 0; i < 100; i++) begin
         cyc(i < 14, 8'(8'h60 + i), 0, 0, 0);
         chk("hold_dout", int'(fifo_dout), 8'h55);
      end
      chk("hold_level", int'(level), 15);
      for (int i = 0; i < 15; i++) cyc(0, 8'h00, 1, 0, 0);
      chk("hold_drained", int'(level), 0);

      // Flush outranks a simultaneous write and pop.
      for (int i = 0; i < 5; i++) cyc(1, 8'(8'h30 + i), 0, 0, 0);
      chk("pre_flush_level", int'(level), 5);
      cyc(1, 8'h77, 1, 1, 0);
      chk("flush_level", int'(level), 0);
      chk("flush_valid", int'(fifo_valid), 0);
      cyc(0, 8'h00, 0, 0, 0);
      chk("flush_nowrite", int'(fifo_valid), 0);

      // Underflow, clear, and pointers intact afterwards.
      cyc(0, 8'h00, 1, 0, 0);
      chk("unf_flag", int'(underflow), int'(c_err));
      cyc(0, 8'h00, 0, 0, 1);
      chk("unf_clr", int'(underflow), 0);
      cyc(1, 8'h99, 0, 0, 0);
      cyc(0, 8'h00, 0, 0, 0);
      chk("post_unf_dout", int'(fifo_dout), 8'h99);

      // Simultaneous write and pop with RAM empty.
      cyc(1, 8'h22, 1, 0, 0);
      chk("wp_valid", int'(fifo_valid), 0);
      chk("wp_level", int'(level), 1);
      cyc(0, 8'h00, 0, 0, 0);
      chk("wp_dout", int'(fifo_dout), 8'h22);

      // Asynchronous reset mid-operation.
      for (int i = 0; i < 3; i++) cyc(1, 8'(8'hC0 + i), 0, 0, 0);
      #2;
      rst_n = 1'b0;
      m_reset();
      #1;
      chk("arst_level", int'(level), 0);
      chk("arst_valid", int'(fifo_valid), 0);
      @(negedge clk);
      rst_n = 1'b1;
      cyc(0, 8'h00, 0, 0, 0);
      chk("arst_hold", int'(level), 0);

      check_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
